// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one N-bit ALU between two requesters. Round-robin choice
//            on ties, then a fixed IDLE -> EXEC -> DONE sequence: the winner's
//            operands are latched into the ALU drive registers, the ALU result
//            and status flags are captured at the end of EXEC, and a one-cycle
//            done pulse is returned to the owner.
// Ports    : clk, rst                     clock, synchronous active-high reset
//            req0/1, a0/1, b0/1,          request, operands, select code and
//            sel0/1, cin0/1               carry-in from each requester
//            gnt0/1, done0/1, busy        handshake pulses and activity flag
//            alu_a, alu_b, alu_select,    registered drive to the shared ALU
//            alu_cin
//            alu_q, alu_cout              combinational ALU response
//            result, zero, carry_flag,    captured result and flags of the
//            overflow, negative           last completed operation
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    input  logic [2:0]   sel0,
    input  logic [2:0]   sel1,
    input  logic         cin0,
    input  logic         cin1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic         busy,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_select,
    output logic         alu_cin,
    input  logic [N-1:0] alu_q,
    input  logic         alu_cout,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         carry_flag,
    output logic         overflow,
    output logic         negative
);

    localparam logic [2:0] C_SEL_ADD = 3'd3;
    localparam logic [2:0] C_SEL_SUB = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_last;     // requester served most recently
    logic   r_owner;    // requester owning the operation in flight
    logic   w_any;
    logic   w_pick1;    // requester 1 wins this IDLE cycle

    assign w_any   = req0 | req1;
    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign w_pick1 = req1 & (~req0 | ~r_last);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_EXEC;
            S_EXEC:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_last     <= 1'b1;
            r_owner    <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            busy       <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_select <= '0;
            alu_cin    <= 1'b0;
            result     <= '0;
            zero       <= 1'b0;
            carry_flag <= 1'b0;
            overflow   <= 1'b0;
            negative   <= 1'b0;
        end else begin
            r_state <= w_next;
            busy    <= (w_next != S_IDLE);
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        alu_a      <= w_pick1 ? a1   : a0;
                        alu_b      <= w_pick1 ? b1   : b0;
                        alu_select <= w_pick1 ? sel1 : sel0;
                        alu_cin    <= w_pick1 ? cin1 : cin0;
                        r_owner    <= w_pick1;
                        r_last     <= w_pick1;
                        gnt0       <= ~w_pick1;
                        gnt1       <= w_pick1;
                    end
                end
                S_EXEC: begin
                    // Capture and raise done on the same edge so that done and
                    // the new result appear together in the DONE cycle.
                    result     <= alu_q;
                    zero       <= (alu_q == '0);
                    carry_flag <= alu_cout & ((alu_select == C_SEL_ADD) ||
                                              (alu_select == C_SEL_SUB));
                    overflow   <= alu_cout & (alu_select == C_SEL_ADD);
                    negative   <= alu_cout & (alu_select == C_SEL_SUB);
                    done0      <= ~r_owner;
                    done1      <= r_owner;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter. A stimulus process predicts
//            each grant and completion from the arbitration and timing rules
//            and queues them; a monitor pops and compares on every gnt/done
//            pulse and checks the held outputs every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [2:0] sel0 = '0, sel1 = '0;
    logic       cin0 = 1'b0, cin1 = 1'b0;
    logic       gnt0, gnt1, done0, done1, busy;
    logic [3:0] alu_a, alu_b, alu_q, result;
    logic [2:0] alu_select;
    logic       alu_cin, alu_cout;
    logic       zero, carry_flag, overflow, negative;

    alu_arbiter #(.N(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .sel0(sel0), .sel1(sel1), .cin0(cin0), .cin1(cin1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_cin(alu_cin),
        .alu_q(alu_q), .alu_cout(alu_cout),
        .result(result), .zero(zero), .carry_flag(carry_flag),
        .overflow(overflow), .negative(negative)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: 3 = add, 4 = subtract (cout = borrow), others logical
    // with cout = parity of a^b so masked flags see a live carry.
    function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] s, input logic c);
        int x;
        case (s)
            3'd0: return {^(a ^ b), a & b};
            3'd1: return {^(a ^ b), a | b};
            3'd2: return {^(a ^ b), a ^ b};
            3'd3: begin x = int'(a) + int'(b) + int'(c); return 5'(x); end
            3'd4: begin
                x = int'(a) - int'(b) - int'(c);
                return {x < 0, 4'(x)};
            end
            3'd5: return {^(a ^ b), ~a};
            3'd6: return {^(a ^ b), a};
            default: return {^(a ^ b), b};
        endcase
    endfunction

    assign {alu_cout, alu_q} = alu_fn(alu_a, alu_b, alu_select, alu_cin);

    typedef struct {
        int         due;
        logic       who;
        logic [11:0] drive;   // {a, b, sel, cin}
    } grant_t;

    typedef struct {
        int         due;
        logic       who;
        logic [7:0] res;      // {q, zero, carry, overflow, negative}
    } done_t;

    grant_t gq[$];
    done_t  dq[$];
    int     cyc = 0;
    int     free_cyc = 0;     // first cycle the arbiter is back in IDLE
    logic   m_last = 1'b1;
    logic [11:0] exp_drive = '0;
    logic [7:0]  exp_res = '0;
    int     n_chk = 0;
    int     n_fail = 0;

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs and predict the arbiter's reaction to them.
    task automatic drive_cycle(input logic rv, input logic r0, input logic r1,
                               input logic [3:0] xa0, input logic [3:0] xb0,
                               input logic [2:0] xs0, input logic xc0,
                               input logic [3:0] xa1, input logic [3:0] xb1,
                               input logic [2:0] xs1, input logic xc1,
                               output int won);
        grant_t g;
        done_t  d;
        logic [4:0] r;
        logic [2:0] s;
        @(negedge clk);
        rst = rv; req0 = r0; req1 = r1;
        a0 = xa0; b0 = xb0; sel0 = xs0; cin0 = xc0;
        a1 = xa1; b1 = xb1; sel1 = xs1; cin1 = xc1;
        won = -1;
        if (rv) begin
            gq.delete(); dq.delete();
            m_last = 1'b1; free_cyc = 0;
            exp_drive = '0; exp_res = '0;
        end else if (cyc >= free_cyc && (r0 || r1)) begin
            g.who = (r0 && r1) ? ~m_last : r1;
            m_last = g.who;
            won = int'(g.who);
            g.due = cyc + 1;
            g.drive = g.who ? {xa1, xb1, xs1, xc1} : {xa0, xb0, xs0, xc0};
            s = g.drive[3:1];
            r = alu_fn(g.drive[11:8], g.drive[7:4], s, g.drive[0]);
            d.due = cyc + 2;
            d.who = g.who;
            d.res = {r[3:0], r[3:0] == 4'd0,
                     r[4] && (s == 3'd3 || s == 3'd4),
                     r[4] && s == 3'd3,
                     r[4] && s == 3'd4};
            gq.push_back(g);
            dq.push_back(d);
            free_cyc = cyc + 3;
        end
    endtask

    task automatic idle(input int n);
        int w;
        for (int i = 0; i < n; i++)
            drive_cycle(0, 0, 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                        4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), w);
    endtask

    task automatic check_reset_outputs();
        @(posedge clk); #1;
        chk("reset_outputs", {gnt0, gnt1, done0, done1, busy, alu_a, alu_b, alu_select,
                              alu_cin, result, zero, carry_flag, overflow, negative}, 0);
    endtask

    // Monitor: one sample per cycle, 1 time unit after the rising edge.
    initial begin
        grant_t g;
        done_t  d;
        forever begin
            @(posedge clk); #1;
            if (gq.size() > 0 && gq[0].due < cyc) begin
                g = gq.pop_front();
                chk("grant_missing", 0, 1);
            end
            if (dq.size() > 0 && dq[0].due < cyc) begin
                d = dq.pop_front();
                chk("done_missing", 0, 1);
            end
            if (gnt0 || gnt1) begin
                if (gq.size() == 0) chk("grant_unexpected", {gnt1, gnt0}, 0);
                else begin
                    g = gq.pop_front();
                    chk("gnt_cycle", cyc, g.due);
                    chk("gnt_who", {gnt1, gnt0}, g.who ? 2'b10 : 2'b01);
                    exp_drive = g.drive;
                end
            end
            if (done0 || done1) begin
                if (dq.size() == 0) chk("done_unexpected", {done1, done0}, 0);
                else begin
                    d = dq.pop_front();
                    chk("done_cycle", cyc, d.due);
                    chk("done_who", {done1, done0}, d.who ? 2'b10 : 2'b01);
                    exp_res = d.res;
                end
            end
            chk("busy", busy, cyc < free_cyc);
            chk("alu_drive", {alu_a, alu_b, alu_select, alu_cin}, exp_drive);
            chk("result_flags", {result, zero, carry_flag, overflow, negative}, exp_res);
        end
    end

    initial begin
        int  w;
        logic r0, r1, p0, p1;
        // Power-on reset.
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, w);
        drive_cycle(1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, w);
        check_reset_outputs();

        // Reset during EXEC discards the operation; the next tie goes to 0.
        drive_cycle(0, 1, 0, 4'd5, 4'd3, 3'd3, 0, 0, 0, 0, 0, w);
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, w);
        check_reset_outputs();
        drive_cycle(0, 1, 1, 4'd1, 4'd1, 3'd3, 0, 4'd2, 4'd2, 3'd3, 0, w);
        chk("tie_after_reset_winner", w, 0);
        idle(3);

        // Add 9+9 with operands changed during EXEC.
        drive_cycle(0, 1, 0, 4'd9, 4'd9, 3'd3, 0, 0, 0, 0, 0, w);
        drive_cycle(0, 0, 0, 4'd15, 4'd1, 3'd5, 1, 0, 0, 0, 0, w);
        idle(2);
        chk("add_result", {result, zero, carry_flag, overflow, negative}, {4'd2, 4'b0110});

        // Subtract 3-5 with borrow.
        drive_cycle(0, 0, 1, 0, 0, 0, 0, 4'd3, 4'd5, 3'd4, 0, w);
        idle(3);
        chk("sub_result", {result, zero, carry_flag, overflow, negative}, {4'd14, 4'b0101});

        // Logical op giving zero with cout=1, then a non-zero op clears zero.
        drive_cycle(0, 1, 0, 4'd5, 4'd2, 3'd0, 0, 0, 0, 0, 0, w);
        idle(3);
        chk("zero_result", {result, zero, carry_flag, overflow, negative}, {4'd0, 4'b1000});
        drive_cycle(0, 0, 1, 0, 0, 0, 0, 4'd1, 4'd2, 3'd1, 0, w);
        idle(3);
        chk("zero_cleared", {result, zero}, {4'd3, 1'b0});

        // Both requests held from reset: grants alternate at cycles 1,4,7,10.
        drive_cycle(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, w);
        for (int i = 0; i < 12; i++)
            drive_cycle(0, 1, 1, 4'(i), 4'(i + 3), 3'(i), 1'(i), 4'(i + 7), 4'(i + 1),
                        3'(i + 3), 1'(i + 1), w);
        idle(3);

        // Randomized traffic: pending requests stay high until granted.
        p0 = 0; p1 = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                drive_cycle(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            0, 0, 0, 0, 0, 0, 0, 0, w);
                p0 = 0; p1 = 0;
            end else begin
                r0 = p0 || ($urandom_range(0, 3) == 0);
                r1 = p1 || ($urandom_range(0, 3) == 0);
                drive_cycle(0, r0, r1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), w);
                p0 = r0 && (w != 0);
                p1 = r1 && (w != 1);
            end
        end
        idle(6);
        @(posedge clk); #2;
        chk("queues_drained", gq.size() + dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `method_ALU` instance (N-bit, 3-bit `select`, `cin`, result `Q`, carry-out `cout`) between two requesters. Round-robin arbitration; a fixed three-state sequence issues one operation, registers the result and status flags, and returns them with a done pulse. It sits between the lab's front-end requesters (switch/FSM drivers) and the shared ALU. Its registered result feeds the seven-segment decoder.

## Interface
- `N`, 4, operand/result width.
- `clk` in 1, rising-edge clock.
- `rst` in 1, synchronous, active-high reset.
- `req0`, `req1` in 1 each, operation request from requester 0 / 1.
- `a0`, `b0`, `a1`, `b1` in N each, operands per requester.
- `sel0`, `sel1` in 3 each, ALU select code per requester.
- `cin0`, `cin1` in 1 each, carry-in per requester.
- `gnt0`, `gnt1` out 1 each, one-cycle grant pulse; operands were sampled on the edge that raised it.
- `done0`, `done1` out 1 each, one-cycle completion pulse to the granted requester.
- `busy` out 1, high whenever state ≠ IDLE.
- `alu_a`, `alu_b` out N, `alu_select` out 3, `alu_cin` out 1, registered drive to the ALU.
- `alu_q` in N, `alu_cout` in 1, combinational ALU response.
- `result` out N, last captured `alu_q`.
- `zero`, `carry_flag`, `overflow`, `negative` out 1 each, flags of the last captured operation.

## Operation
- States: IDLE → EXEC → DONE → IDLE. There are no other transitions, and no operation is ever aborted except by reset.
- **IDLE**: if any `req` is high, choose the winner, latch its a/b/sel/cin into the ALU drive registers, record the owner, pulse its `gnt`, and go to EXEC. With no request, stay in IDLE with the drive registers unchanged.
- **Arbitration**:
  - If only one request is present, it wins.
  - If both are present, the requester not served last wins.
  - `last` pointer after reset = 1, so requester 0 wins the first tie.
  - `last` updates only on grant.
- **EXEC**: the ALU sees stable latched inputs for the full cycle. On exit, capture into registers:
  - `result` ← `alu_q`.
  - `zero` ← (`alu_q` == 0).
  - `carry_flag` ← `alu_cout` if select ∈ {3,4}, else 0.
  - `overflow` ← `alu_cout` if select = 3 (add), else 0.
  - `negative` ← `alu_cout` if select = 4 (subtract, borrow), else 0.
  - All four flags are recomputed on every operation; none is sticky.
- **DONE**: pulse the owner's `done`, then go to IDLE.
  - Requests are not sampled in DONE or EXEC.
  - A request held high is served on the next IDLE cycle.
- **Request and output hold rules**:
  - A requester may drop `req` any time after its `gnt`.
  - A `req` still high after `done` is a new request.
  - `result` and the flags hold until the next EXEC capture.
  - `alu_*` drive registers hold until the next grant.
- **Widths**: all datapath is N bits. No result extension; `alu_cout` is the only carry source.
- **Reset** (any state, including mid-operation):
  - State → IDLE; pending operation discarded, no `done` issued.
  - `last` ← 1.
  - All outputs reset to 0: `gnt*`, `done*`, `busy`, `alu_a`, `alu_b`, `alu_select`, `alu_cin`, `result`, all flags.
  - Requests present during the reset cycle are ignored. Arbitration resumes on the first cycle with `rst` low.

## Timing
- Cycle t: IDLE, `req` high.
- Edge t+1: grant; `gnt` high and `busy` high during cycle t+1 (EXEC).
- Edge t+2: capture; `done` high and flags/`result` valid from cycle t+2.
- Edge t+3: IDLE.
- Request-to-done latency: 2 cycles.
- Maximum throughput: one operation per 3 cycles; back-to-back grants are 3 cycles apart.
- All outputs are registered; there is no combinational path from `req` or `alu_q` to any output.

## Test plan
- **Reset mid-op**: grant req0 (A=5, B=3, sel=3), assert `rst` in EXEC → no `done0`; all outputs 0; state IDLE next cycle; next tie grants requester 0.
- **Single add**: req0 with A=9, B=9, sel=3, cin=0 (ALU returns Q=2, cout=1) → `gnt0` at t+1, `done0` at t+2, result=2, carry_flag=1, overflow=1, negative=0, zero=0.
- **Subtract with borrow**: req1 with A=3, B=5, sel=4 (ALU returns Q=14, cout=1) → `done1` at t+2, negative=1, carry_flag=1, overflow=0.
- **Zero result with non-arithmetic op**: a sel that yields Q=0 with cout=1 → zero=1 and the other three flags 0. Then a following op with Q≠0 → zero cleared (not sticky).
- **Round-robin**: req0 and req1 held high continuously from reset → grants alternate 0,1,0,1 at cycles 1,4,7,10, each `done` 1 cycle after its `gnt`.
- **Operand stability**: change a0/sel0 during EXEC after `gnt0` → `alu_a`/`alu_select` keep the values latched at the grant, and the captured result matches those latched values.
